reg_arbiter: RTL and testbench
==============================

Name: reg_arbiter

Overview:
- Shares one register-file port among N requesters, e.g. the AXI register bridge plus a local sequencer or debug master.
- Round-robin arbitration with one transaction in flight at a time.
- Drives the register file's rd/raddr/wr/waddr/wdata and captures rdata after a fixed read latency.
- Returns a one-cycle response pulse to the winning requester.

Parameters:
- N, 2, number of requesters (2..8).
- AW, 2, register address width (word index).
- RD_LATENCY, 2, cycles from rm_rd assertion to valid rm_rdata (1..4).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  N  requester i has a pending transaction
- req_we  in  N  1 = write, 0 = read
- req_addr  in  N*AW  address; requester i occupies bits [i*AW +: AW]
- req_wdata  in  N*32  write data; requester i occupies bits [i*32 +: 32]
- req_ready  out  N  one-hot accept; a transfer occurs when req_valid[i] & req_ready[i]
- rsp_valid  out  N  one-hot, one-cycle completion pulse
- rsp_rdata  out  32  read data; valid with rsp_valid, held until the next read capture
- rm_rd  out  1  register file read strobe
- rm_raddr  out  AW  read address
- rm_wr  out  1  register file write strobe
- rm_waddr  out  AW  write address
- rm_wdata  out  32  write data
- rm_rdata  in  32  register file read data

Behaviour:
- Reset values: state=IDLE, pointer=N-1 (requester 0 wins first), all outputs 0, rsp_rdata=0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready is combinational: one-hot to the first requester with req_valid set, searching pointer+1, pointer+2, ... modulo N.
  - On accept: latch index, we, addr, wdata; pointer <= index; go to ISSUE.
  - No request: stay in IDLE, req_ready=0.
- req_ready is 0 in every state other than IDLE. Requesters must hold addr/wdata/we stable while req_valid is high and not yet accepted.
- ISSUE, write: rm_wr=1, rm_waddr and rm_wdata from the latch, rsp_valid[index]=1, all for exactly this one cycle. Next state IDLE.
- ISSUE, read: rm_rd=1 and rm_raddr from the latch for exactly one cycle. Load the latency counter with RD_LATENCY-1, then go to WAIT, or go straight to RESP when RD_LATENCY=1.
- WAIT: decrement the counter. When the counter reaches 0, capture rm_rdata into rsp_rdata and go to RESP.
- RESP: rsp_valid[index]=1 for one cycle; next state IDLE.
- Read timing: accept in cycle 0, rm_rd in cycle 1, rdata sampled in cycle 1+RD_LATENCY, rsp_valid in cycle 2+RD_LATENCY, next accept possible in cycle 3+RD_LATENCY.
- Write timing: accept in cycle 0, rm_wr and rsp_valid in cycle 1, next accept possible in cycle 2.
- rm_raddr/rm_waddr/rm_wdata hold their last value when the strobes are idle. rsp_valid has no backpressure; the requester must take it.
- Pointer wrap: after granting N-1, the search starts at 0.
- A requester dropping req_valid before accept is legal; it is simply not granted.
- Reset while in any state returns to IDLE on the next edge. An in-flight transaction is dropped with no rsp_valid, and strobes are 0 in the following cycle.

Optional Feature:
- Macro: REG_ARB_LOCK_EN.
- When defined:
  - Extra input port req_lock [N-1:0].
  - If the accepted requester has req_lock set at accept, it becomes owner. In IDLE only the owner may be granted; others wait even if the owner's req_valid is low.
  - Ownership releases when the owner completes a transaction accepted with req_lock=0.
  - Reset clears ownership.
- When undefined: no req_lock port; pure round-robin as above.

Test Plan:
- Write: req0 valid, we=1, addr=3, wdata=0xDEADBEEF -> one cycle after accept, rm_wr=1 for exactly one cycle with rm_waddr=3, rm_wdata=0xDEADBEEF, and rsp_valid=2'b01 in the same cycle.
- Read, RD_LATENCY=2: req1 reads addr=1; model returns 0x12345678 two cycles after rm_rd -> rm_rd for one cycle with rm_raddr=1, rsp_valid=2'b10 in cycle 4 after accept, rsp_rdata=0x12345678 and held afterwards.
- Contention: both requesters continuously valid with writes from reset -> grant order 0,1,0,1,0,1 and one accept every 2 cycles.
- Single requester: only req1 valid with back-to-back reads, RD_LATENCY=1 -> accepts every 4 cycles, all to requester 1.
- Reset during WAIT -> no rsp_valid, all strobes 0; first post-reset grant goes to requester 0 even with both valid.
- REG_ARB_LOCK_EN: req0 issues 3 transactions with req_lock=1,1,0 while req1 stays valid -> req1 is granted only after req0's third response.

Source files
------------

// File: rtl/reg_arbiter.sv
// -----------------------------------------------------------------------------
// reg_arbiter
//
// Shares one register-file port among N requesters (e.g. the AXI register
// bridge, a local sequencer and a debug master). Requesters are served
// round-robin with a single transaction in flight. Writes complete one cycle
// after accept; reads wait RD_LATENCY cycles for rm_rdata and then return it
// with a one-cycle rsp_valid pulse.
//
// Optional feature, enabled by defining REG_ARB_LOCK_EN:
//   adds input req_lock. A requester accepted with req_lock=1 becomes the
//   owner; while an owner exists only it can be granted. Ownership is released
//   when the owner completes a transaction that was accepted with req_lock=0.
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous, active-high reset
//   req_valid  in   [N]     pending transaction per requester
//   req_we     in   [N]     1 = write, 0 = read
//   req_addr   in   [N*AW]  requester i at bits [i*AW +: AW]
//   req_wdata  in   [N*32]  requester i at bits [i*32 +: 32]
//   req_lock   in   [N]     ownership request (REG_ARB_LOCK_EN only)
//   req_ready  out  [N]     one-hot accept, only in IDLE
//   rsp_valid  out  [N]     one-hot, one-cycle completion pulse
//   rsp_rdata  out  [32]    read data, held until the next read capture
//   rm_rd      out          register file read strobe
//   rm_raddr   out  [AW]    read address (holds when idle)
//   rm_wr      out          register file write strobe
//   rm_waddr   out  [AW]    write address (holds when idle)
//   rm_wdata   out  [32]    write data (holds when idle)
//   rm_rdata   in   [32]    register file read data
//
// States:
//   state | meaning
//   IDLE  | arbitrating; req_ready driven combinationally
//   ISSUE | strobe the register file for one cycle (writes also respond here)
//   WAIT  | counting down the read latency; capture rm_rdata at zero
//   RESP  | pulse rsp_valid for a completed read
// -----------------------------------------------------------------------------
module reg_arbiter #(
    parameter int N          = 2,
    parameter int AW         = 2,
    parameter int RD_LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req_valid,
    input  logic [N-1:0]    req_we,
    input  logic [N*AW-1:0] req_addr,
    input  logic [N*32-1:0] req_wdata,
`ifdef REG_ARB_LOCK_EN
    input  logic [N-1:0]    req_lock,
`endif
    output logic [N-1:0]    req_ready,
    output logic [N-1:0]    rsp_valid,
    output logic [31:0]     rsp_rdata,
    output logic            rm_rd,
    output logic [AW-1:0]   rm_raddr,
    output logic            rm_wr,
    output logic [AW-1:0]   rm_waddr,
    output logic [31:0]     rm_wdata,
    input  logic [31:0]     rm_rdata
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   idx_q;
    logic            we_q;
    logic [CW-1:0]   cnt_q;

    logic [N-1:0]    eligible;
    logic            grant_found;
    logic [IW-1:0]   grant_idx;
    logic            accept;
    int              cand;

`ifdef REG_ARB_LOCK_EN
    logic            owner_v_q;
    logic [IW-1:0]   owner_q;
    logic            lock_q;
    logic [N-1:0]    owner_mask;
`endif

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Requesters eligible for a grant this cycle. With locking, an owner
    // blocks everyone else even while its own req_valid is low.
    always_comb begin
`ifdef REG_ARB_LOCK_EN
        owner_mask = onehot(owner_q);
        eligible   = owner_v_q ? (req_valid & owner_mask) : req_valid;
`else
        eligible   = req_valid;
`endif
    end

    // Round-robin search starting just after the last winner.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(ptr_q) + k) % N;
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = IW'(cand);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = '0;
        rm_rd     = 1'b0;
        rm_wr     = 1'b0;
        accept    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    req_ready = onehot(grant_idx);
                    accept    = 1'b1;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (we_q) begin
                    rm_wr     = 1'b1;
                    rsp_valid = onehot(idx_q);
                    state_d   = ST_IDLE;
                end else begin
                    rm_rd     = 1'b1;
                    // Reads always pass through WAIT: the counter starts at
                    // RD_LATENCY-1, so WAIT lasts RD_LATENCY cycles and the
                    // capture lands RD_LATENCY cycles after rm_rd, including
                    // the RD_LATENCY=1 case.
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = onehot(idx_q);
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The rm_* address/data registers double as the transaction latch: they
    // are loaded at accept so they are valid during ISSUE, and otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= IW'(N - 1);
            idx_q     <= '0;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            rsp_rdata <= '0;
            rm_raddr  <= '0;
            rm_waddr  <= '0;
            rm_wdata  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                idx_q <= grant_idx;
                ptr_q <= grant_idx;
                we_q  <= req_we[grant_idx];
                if (req_we[grant_idx]) begin
                    rm_waddr <= req_addr[grant_idx*AW +: AW];
                    rm_wdata <= req_wdata[grant_idx*32 +: 32];
                end else begin
                    rm_raddr <= req_addr[grant_idx*AW +: AW];
                end
            end
            if (state_q == ST_ISSUE && !we_q) begin
                cnt_q <= CW'(RD_LATENCY - 1);
            end
            if (state_q == ST_WAIT) begin
                if (cnt_q == '0) begin
                    rsp_rdata <= rm_rdata;
                end else begin
                    cnt_q <= cnt_q - CW'(1);
                end
            end
        end
    end

`ifdef REG_ARB_LOCK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_v_q <= 1'b0;
            owner_q   <= '0;
            lock_q    <= 1'b0;
        end else begin
            if (accept) begin
                lock_q <= req_lock[grant_idx];
                if (req_lock[grant_idx]) begin
                    owner_v_q <= 1'b1;
                    owner_q   <= grant_idx;
                end
            end
            // Release on completion of the owner's unlocked transaction.
            if ((|rsp_valid) && !lock_q && owner_v_q && (owner_q == idx_q)) begin
                owner_v_q <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_arbiter
//
// Two arbiters share the requester inputs: u_dut0 (RD_LATENCY=2) and u_dut1
// (RD_LATENCY=1). Only one is active at a time; the other is held in reset.
// Each has its own register-file model with a read pipeline of its latency.
// A transaction-level model predicts grants and the cycle of every strobe and
// response from the timing rules; all outputs are compared every cycle.
// -----------------------------------------------------------------------------
module tb_reg_arbiter;
    localparam int N  = 2;
    localparam int AW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset0, reset1;
    logic [N-1:0]     req_valid, req_we;
    logic [N*AW-1:0]  req_addr;
    logic [N*32-1:0]  req_wdata;
`ifdef REG_ARB_LOCK_EN
    logic [N-1:0]     req_lock;
`endif

    logic [N-1:0]     ready0, ready1, rspv0, rspv1;
    logic [31:0]      rdata0, rdata1, wdata0, wdata1, rmr0, rmr1;
    logic             rd0, rd1, wr0, wr1;
    logic [AW-1:0]    raddr0, raddr1, waddr0, waddr1;

    reg_arbiter #(.N(N), .AW(AW), .RD_LATENCY(2)) u_dut0 (
        .clk(clk), .reset(reset0),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef REG_ARB_LOCK_EN
        .req_lock(req_lock),
`endif
        .req_ready(ready0), .rsp_valid(rspv0), .rsp_rdata(rdata0),
        .rm_rd(rd0), .rm_raddr(raddr0), .rm_wr(wr0), .rm_waddr(waddr0),
        .rm_wdata(wdata0), .rm_rdata(rmr0)
    );

    reg_arbiter #(.N(N), .AW(AW), .RD_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset1),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef REG_ARB_LOCK_EN
        .req_lock(req_lock),
`endif
        .req_ready(ready1), .rsp_valid(rspv1), .rsp_rdata(rdata1),
        .rm_rd(rd1), .rm_raddr(raddr1), .rm_wr(wr1), .rm_waddr(waddr1),
        .rm_wdata(wdata1), .rm_rdata(rmr1)
    );

    // Register-file models. Data not produced by a read is junk so that a
    // capture at the wrong cycle is visible.
    logic [31:0] mem0 [4];
    logic [31:0] mem1 [4];
    logic [31:0] p0a, p0b, p1a;
    logic [15:0] junk_cnt = '0;

    always @(posedge clk) begin
        junk_cnt <= junk_cnt + 16'd1;
        if (wr0) mem0[waddr0] <= wdata0;
        if (wr1) mem1[waddr1] <= wdata1;
        p0a <= rd0 ? mem0[raddr0] : {16'hBAD0, junk_cnt};
        p0b <= p0a;
        p1a <= rd1 ? mem1[raddr1] : {16'hBAD1, junk_cnt};
    end
    assign rmr0 = p0b;
    assign rmr1 = p1a;

    // Observed outputs of whichever arbiter is active.
    logic             sel;
    logic [N-1:0]     o_ready, o_rspv;
    logic [31:0]      o_rdata, o_wdata;
    logic             o_rd, o_wr;
    logic [AW-1:0]    o_raddr, o_waddr;
    assign o_ready = sel ? ready1 : ready0;
    assign o_rspv  = sel ? rspv1  : rspv0;
    assign o_rdata = sel ? rdata1 : rdata0;
    assign o_wdata = sel ? wdata1 : wdata0;
    assign o_rd    = sel ? rd1    : rd0;
    assign o_wr    = sel ? wr1    : wr0;
    assign o_raddr = sel ? raddr1 : raddr0;
    assign o_waddr = sel ? waddr1 : waddr0;

    // Requester state
    bit              pv  [N];
    bit              pwe [N];
    bit              plk [N];
    logic [AW-1:0]   paddr [N];
    logic [31:0]     pwd [N];

    // Reference model state
    int              cyc, m_ptr, m_free, e_wr, e_rd, e_rsp, e_idx, own;
    bit              e_is_read, own_v, rst_now;
    logic [AW-1:0]   w_addr, r_addr, m_raddr, m_waddr;
    logic [31:0]     w_data, r_data, m_wdata, m_rdata;
    logic [31:0]     shadow [4];
    int              g_idx[$];
    int              g_cyc[$];
    int              r_cyc[$];

    int              n_checks, n_pass;

    function automatic logic [31:0] init_val(input int a);
        return (a == 1) ? 32'h1234_5678 : 32'h1000_0000 + 32'(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, cyc);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]            = pv[i];
            req_we[i]               = pwe[i];
            req_addr[i*AW +: AW]    = paddr[i];
            req_wdata[i*32 +: 32]   = pwd[i];
`ifdef REG_ARB_LOCK_EN
            req_lock[i]             = plk[i];
`endif
        end
    endtask

    task automatic model_reset();
        m_ptr   = N - 1;
        m_free  = cyc + 1;
        e_wr    = -1;
        e_rd    = -1;
        e_rsp   = -1;
        own_v   = 1'b0;
        m_raddr = '0;
        m_waddr = '0;
        m_wdata = '0;
        m_rdata = '0;
    endtask

    task automatic set_reset(input bit b);
        if (sel) reset1 = b;
        else     reset0 = b;
        rst_now = b;
    endtask

    task automatic run_cycle();
        int lat, g, j;
        logic [N-1:0] exp_ready, exp_rsp;
        drive();
        #1;
        lat = sel ? 1 : 2;
        if (rst_now) begin
            model_reset();
        end else begin
            g = -1;
            if (cyc >= m_free) begin
                for (int k = 1; k <= N; k++) begin
                    j = (m_ptr + k) % N;
                    if (g < 0 && pv[j] && (!own_v || own == j)) g = j;
                end
            end
            if (cyc == e_wr) begin
                m_waddr        = w_addr;
                m_wdata        = w_data;
                shadow[w_addr] = w_data;
            end
            if (cyc == e_rd) m_raddr = r_addr;
            if (cyc == e_rsp && e_is_read) m_rdata = r_data;
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            exp_rsp = '0;
            if (cyc == e_rsp) exp_rsp[e_idx] = 1'b1;
            if (o_rspv != '0) r_cyc.push_back(cyc);

            check("req_ready", 32'(o_ready), 32'(exp_ready));
            check("rsp_valid", 32'(o_rspv),  32'(exp_rsp));
            check("rm_rd",     32'(o_rd),    32'(cyc == e_rd));
            check("rm_wr",     32'(o_wr),    32'(cyc == e_wr));
            check("rm_raddr",  32'(o_raddr), 32'(m_raddr));
            check("rm_waddr",  32'(o_waddr), 32'(m_waddr));
            check("rm_wdata",  o_wdata,      m_wdata);
            check("rsp_rdata", o_rdata,      m_rdata);

            if (g >= 0) begin
                g_idx.push_back(g);
                g_cyc.push_back(cyc);
                m_ptr = g;
                e_idx = g;
                if (pwe[g]) begin
                    e_wr      = cyc + 1;
                    e_rsp     = cyc + 1;
                    e_is_read = 1'b0;
                    w_addr    = paddr[g];
                    w_data    = pwd[g];
                    m_free    = cyc + 2;
                end else begin
                    e_rd      = cyc + 1;
                    e_rsp     = cyc + 2 + lat;
                    e_is_read = 1'b1;
                    r_addr    = paddr[g];
                    r_data    = shadow[paddr[g]];
                    m_free    = cyc + 3 + lat;
                end
                if (plk[g]) begin
                    own_v = 1'b1;
                    own   = g;
                end else if (own_v && own == g) begin
                    own_v = 1'b0;
                end
                pv[g] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic new_req(input int i, input bit we, input bit lk);
        pv[i]    = 1'b1;
        pwe[i]   = we;
        plk[i]   = lk;
        paddr[i] = AW'($urandom_range(0, 3));
        pwd[i]   = $urandom;
    endtask

    initial begin
        int base, guard, n0;
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        sel      = 1'b0;
        reset0   = 1'b1;
        reset1   = 1'b1;
        rst_now  = 1'b1;
        e_idx    = 0;
        own      = 0;
        e_is_read = 1'b0;
        w_addr = '0; r_addr = '0; w_data = '0; r_data = '0;
        for (int i = 0; i < N; i++) begin
            pv[i] = 0; pwe[i] = 0; plk[i] = 0; paddr[i] = '0; pwd[i] = '0;
        end
        for (int a = 0; a < 4; a++) begin
            mem0[a]   = init_val(a);
            mem1[a]   = init_val(a);
            shadow[a] = init_val(a);
        end
        model_reset();
        repeat (3) run_cycle();
        set_reset(1'b0);

        // Write from requester 0
        pv[0] = 1; pwe[0] = 1; plk[0] = 0; paddr[0] = 2'd3; pwd[0] = 32'hDEAD_BEEF;
        repeat (4) run_cycle();
        check("wr_grant_req0", 32'(g_idx[g_idx.size()-1]), 32'd0);
        check("wr_wdata_held", o_wdata, 32'hDEAD_BEEF);

        // Read of address 1 by requester 1
        pv[1] = 1; pwe[1] = 0; plk[1] = 0; paddr[1] = 2'd1; pwd[1] = '0;
        repeat (9) run_cycle();
        check("rd_grant_req1", 32'(g_idx[g_idx.size()-1]), 32'd1);
        check("rd_rsp_latency", 32'(r_cyc[r_cyc.size()-1] - g_cyc[g_cyc.size()-1]), 32'd4);
        check("rd_rdata_held", o_rdata, 32'h1234_5678);

        // Contention with writes from reset
        new_req(0, 1, 0);
        new_req(1, 1, 0);
        set_reset(1'b1);
        repeat (2) run_cycle();
        set_reset(1'b0);
        base = g_idx.size();
        repeat (14) begin
            for (int i = 0; i < N; i++) if (!pv[i]) new_req(i, 1, 0);
            run_cycle();
        end
        check("cont_count", 32'(g_idx.size() >= base + 6), 32'd1);
        if (g_idx.size() >= base + 6) begin
            for (int k = 0; k < 6; k++) begin
                check("cont_order", 32'(g_idx[base+k]), 32'(k % 2));
                if (k > 0) check("cont_spacing", 32'(g_cyc[base+k] - g_cyc[base+k-1]), 32'd2);
            end
        end

        // Randomized traffic
        repeat (300) begin
            for (int i = 0; i < N; i++) begin
                if (!pv[i] && $urandom_range(0, 2) == 0) new_req(i, 1'($urandom_range(0, 1)), 0);
                else if (pv[i] && $urandom_range(0, 15) == 0) pv[i] = 0;
            end
            run_cycle();
        end

        // Reset during WAIT of a read
        for (int i = 0; i < N; i++) pv[i] = 0;
        guard = 0;
        while (cyc < m_free && guard < 20) begin run_cycle(); guard++; end
        pv[1] = 1; pwe[1] = 0; plk[1] = 0; paddr[1] = 2'd2;
        n0 = g_idx.size();
        guard = 0;
        while (g_idx.size() == n0 && guard < 10) begin run_cycle(); guard++; end
        check("wrst_accept_seen", 32'(g_idx.size() > n0), 32'd1);
        run_cycle();
        new_req(0, 1, 0);
        new_req(1, 1, 0);
        set_reset(1'b1);
        run_cycle();
        set_reset(1'b0);
        base = g_idx.size();
        n0 = r_cyc.size();
        run_cycle();
        check("wrst_no_rsp", 32'(r_cyc.size()), 32'(n0));
        repeat (4) run_cycle();
        check("wrst_first_grant", 32'(g_idx.size() > base ? g_idx[base] : -1), 32'd0);

`ifdef REG_ARB_LOCK_EN
        // Requester 0 locks for two transactions, unlocks on the third
        for (int i = 0; i < N; i++) pv[i] = 0;
        new_req(1, 1, 0);
        set_reset(1'b1);
        repeat (2) run_cycle();
        set_reset(1'b0);
        base = g_idx.size();
        for (int t = 0; t < 3; t++) begin
            new_req(0, 1, t < 2);
            n0 = g_idx.size();
            guard = 0;
            while (g_idx.size() == n0 && guard < 20) begin run_cycle(); guard++; end
            check("lock_accept", 32'(g_idx.size() > n0), 32'd1);
            repeat (4) run_cycle();
        end
        guard = 0;
        while (g_idx.size() < base + 4 && guard < 20) begin run_cycle(); guard++; end
        check("lock_count", 32'(g_idx.size() >= base + 4), 32'd1);
        if (g_idx.size() >= base + 4) begin
            for (int k = 0; k < 4; k++)
                check("lock_order", 32'(g_idx[base+k]), 32'(k < 3 ? 0 : 1));
        end
        plk[0] = 0;
`endif

        // Single requester, back-to-back reads, RD_LATENCY=1
        for (int i = 0; i < N; i++) pv[i] = 0;
        reset0 = 1'b1;
        sel    = 1'b1;
        set_reset(1'b1);
        repeat (2) run_cycle();
        for (int a = 0; a < 4; a++) shadow[a] = init_val(a);
        set_reset(1'b0);
        base = g_idx.size();
        repeat (24) begin
            if (!pv[1]) new_req(1, 0, 0);
            run_cycle();
        end
        check("l1_count", 32'(g_idx.size() >= base + 5), 32'd1);
        if (g_idx.size() >= base + 5) begin
            for (int k = 0; k < 5; k++) begin
                check("l1_grant_req1", 32'(g_idx[base+k]), 32'd1);
                if (k > 0) check("l1_spacing", 32'(g_cyc[base+k] - g_cyc[base+k-1]), 32'd4);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
